// File: rtl/core_mem_responder_pkg.sv
// Shared definitions for the core memory responder: FSM encoding, the idle
// instruction word and a small address range helper.
package core_mem_responder_pkg;

    // Responder phases: held idle, streaming a program image, core running.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    // addi x0,x0,0 -- harmless instruction fed to the core while it is held.
    localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0013;

    // True when a 32-bit word address fits inside a 2^aw word array.
    function automatic logic addr_in_range(input logic [31:0] addr, input int aw);
        logic [31:0] w_hi;
        w_hi = addr >> aw;
        return (w_hi == 32'd0);
    endfunction

endpackage

// File: rtl/core_mem_responder_word_ram.sv
// Word-addressed RAM: two combinational read ports, one clocked write port.
// No reset on the storage; contents survive core resets and reloads.
module word_ram #(
    parameter int AW = 10,
    parameter int DW = 32
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr_a,
    output logic [DW-1:0] o_rdata_a,
    input  logic [AW-1:0] i_raddr_b,
    output logic [DW-1:0] o_rdata_b
);

    logic [DW-1:0] r_mem [2**AW];

    // Single write port; a same-cycle read still sees the old word.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = r_mem[i_raddr_a];
    assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/core_mem_responder.sv
// Memory-side responder for the pipelined core. Serves instruction fetch and
// data accesses from one unified array, and owns a host port that streams a
// program image into the array while the core is held in reset.
module core_mem_responder
    import core_mem_responder_pkg::*;
#(
    parameter int          AW       = 10,
    parameter logic [31:0] NOP_WORD = NOP_WORD_DEF
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_pc,
    output logic [31:0] o_ir,
    input  logic [31:0] i_d_addr,
    input  logic [31:0] i_d_wdata,
    input  logic        i_d_wen,
    output logic [31:0] o_d_rdata,
    input  logic        i_ld_start,
    input  logic        i_ld_valid,
    output logic        o_ld_ready,
    input  logic [31:0] i_ld_data,
    input  logic        i_ld_last,
    output logic        o_core_rst,
    output logic [AW:0] o_ld_count,
    output logic        o_oob_err
);

    state_e      r_state;
    logic        r_core_rst;
    logic        r_ld_ready;
    logic [AW:0] r_ld_count;
    logic        r_oob_err;

    logic          w_pc_ok;
    logic          w_d_ok;
    logic          w_run;
    logic          w_ld_fire;
    logic          w_core_we;
    logic          w_we;
    logic [AW-1:0] w_waddr;
    logic [31:0]   w_wdata;
    logic [31:0]   w_rd_i;
    logic [31:0]   w_rd_d;
    logic          w_ld_full;

    assign w_pc_ok = addr_in_range(i_pc, AW);
    assign w_d_ok  = addr_in_range(i_d_addr, AW);
    assign w_run   = (r_state == ST_RUN);

    // ld_ready is only ever high in LOAD, so it alone qualifies a transfer.
    assign w_ld_fire = i_ld_valid && r_ld_ready;
    // The transfer in flight fills the last slot of the array.
    assign w_ld_full = (r_ld_count[AW-1:0] == {AW{1'b1}});

    // Loader owns the write port in LOAD, the core in RUN; they never overlap.
    assign w_core_we = w_run && i_d_wen && w_d_ok;
    assign w_we      = w_ld_fire || w_core_we;
    assign w_waddr   = w_ld_fire ? r_ld_count[AW-1:0] : i_d_addr[AW-1:0];
    assign w_wdata   = w_ld_fire ? i_ld_data : i_d_wdata;

    word_ram #(.AW(AW), .DW(32)) u_ram (
        .i_clk     (i_clk),
        .i_we      (w_we),
        .i_waddr   (w_waddr),
        .i_wdata   (w_wdata),
        .i_raddr_a (i_pc[AW-1:0]),
        .o_rdata_a (w_rd_i),
        .i_raddr_b (i_d_addr[AW-1:0]),
        .o_rdata_b (w_rd_d)
    );

    // Sequence IDLE -> LOAD -> RUN, track image length and sticky range errors.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_core_rst <= 1'b1;
            r_ld_ready <= 1'b0;
            r_ld_count <= '0;
            r_oob_err  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_ld_start) begin
                        r_state    <= ST_LOAD;
                        r_ld_ready <= 1'b1;
                        r_ld_count <= '0;
                        r_oob_err  <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    // A new ld_start while streaming is deliberately ignored.
                    if (w_ld_fire) begin
                        r_ld_count <= r_ld_count + (AW+1)'(1);
                        if (i_ld_last || w_ld_full) begin
                            r_state    <= ST_RUN;
                            r_ld_ready <= 1'b0;
                            r_core_rst <= 1'b0;
                        end
                    end
                end
                ST_RUN: begin
                    if (i_ld_start) begin
                        // Reprogram: hold the core again; old contents stay.
                        r_state    <= ST_LOAD;
                        r_core_rst <= 1'b1;
                        r_ld_ready <= 1'b1;
                        r_ld_count <= '0;
                        r_oob_err  <= 1'b0;
                    end else if (!w_pc_ok || (i_d_wen && !w_d_ok)) begin
                        r_oob_err <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_core_rst <= 1'b1;
                    r_ld_ready <= 1'b0;
                end
            endcase
        end
    end

    // The core only sees real memory while running and in range.
    assign o_ir      = (w_run && w_pc_ok) ? w_rd_i : NOP_WORD;
    assign o_d_rdata = (w_run && w_d_ok)  ? w_rd_d : 32'd0;

    assign o_ld_ready = r_ld_ready;
    assign o_core_rst = r_core_rst;
    assign o_ld_count = r_ld_count;
    assign o_oob_err  = r_oob_err;

endmodule

// File: doc/core_mem_responder.md
# core_mem_responder

Memory-side responder for the pipelined core. It serves the core's instruction-fetch port (`pc_out` → `ir`) and data port (`alu_DMEM`/`writedata_DMEM`/`memwrite_MEM` → `readdata_MEM`) from one unified word-addressed array. It also owns a host load port that streams a program image into the array while holding the core in reset. It sits beside the core at the top level; the core sees it purely as combinational-read, clocked-write memory.

## Interface
Parameters:
- `AW`, 10, array address width in words (depth = 2^AW)
- `NOP_WORD`, 32'h0000_0013, instruction driven on `ir` while the core is held

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `pc`  in  32  core fetch word address
- `ir`  out  32  fetched instruction
- `d_addr`  in  32  core data word address (`alu_DMEM`)
- `d_wdata`  in  32  core store data
- `d_wen`  in  1  core store strobe (`memwrite_MEM`)
- `d_rdata`  out  32  load data (`readdata_MEM`)
- `ld_start`  in  1  pulse: begin program load
- `ld_valid`  in  1  host word valid
- `ld_ready`  out  1  responder accepts word
- `ld_data`  in  32  host word
- `ld_last`  in  1  marks final word (qualified by valid&ready)
- `core_rst`  out  1  reset to core (OR'ed with `rst` at top)
- `ld_count`  out  AW+1  words loaded in current/last image
- `oob_err`  out  1  sticky: core accessed address ≥ 2^AW

## Operation
- FSM states: IDLE, LOAD, RUN. Reset → IDLE.
- IDLE: `core_rst`=1, `ld_ready`=0. `ld_start` → LOAD, `ld_count` cleared to 0.
- LOAD: `core_rst`=1, `ld_ready`=1.
  - Each valid&ready writes `ld_data` to address `ld_count[AW-1:0]` and increments `ld_count`.
  - valid&ready&`ld_last` → RUN after that write.
  - If `ld_count` reaches 2^AW without `ld_last` → RUN; further words are not accepted.
  - `ld_start` in LOAD is ignored.
- RUN: `core_rst`=0, `ld_ready`=0.
  - `ld_start` → LOAD (reprogram): `core_rst` reasserts next cycle, `ld_count` cleared. Array contents beyond the new image are retained.
- Fetch: `ir` = array[`pc[AW-1:0]`] in RUN; `NOP_WORD` otherwise. `pc` with any bit ≥ AW set → `ir`=`NOP_WORD` and sets `oob_err`.
- Data read: `d_rdata` = array[`d_addr[AW-1:0]`] when `d_addr` is in range; 0 when out of range or not in RUN.
- Data write: in RUN, `d_wen`=1 with in-range address writes `d_wdata` at the clock edge. Out-of-range write is suppressed and sets `oob_err`. `d_wen` outside RUN is ignored and does not set `oob_err`.
- `oob_err` clears only on `rst` or on entry to LOAD.
- Write-port arbitration: the loader writes only in LOAD and the core only in RUN, so no conflict exists by construction.

## Timing
- Reset values:
  - state = IDLE
  - `core_rst`=1
  - `ld_ready`=0
  - `ld_count`=0
  - `oob_err`=0
  - `ir`=`NOP_WORD`
  - `d_rdata`=0
  - Array contents are not reset.
- Reads are combinational, zero latency. Writes commit at the rising edge.
- Same-cycle read and write of one address returns old data. The new data is visible from the next cycle, so a store followed by a load to the same address one cycle later returns the stored value.
- Load handshake:
  - A word transfers on a rising edge with `ld_valid`&`ld_ready`.
  - The host may hold `ld_valid` high across consecutive cycles for one word per cycle.
  - `ld_data` and `ld_last` must be stable while `ld_valid`=1.
- LOAD→RUN: `core_rst` deasserts the cycle after the last transfer. The core's first fetch at pc=0 sees the loaded word.
- `rst` mid-load aborts immediately to IDLE. Words already written remain in the array.

## Structure
- Shared package: FSM state enum (IDLE/LOAD/RUN) and the `NOP_WORD` default constant.
- One sub-module `word_ram`: 2 combinational read ports, 1 clocked write port, parameterised by `AW`, no reset. It is reused for later split I/D memories.
- FSM, address-range checks, write mux and `oob_err` live in `core_mem_responder`.

## Test plan
- Reset then idle 5 cycles → `core_rst`=1, `ld_ready`=0, `ir`=32'h0000_0013, `d_rdata`=0, `ld_count`=0.
- `ld_start`; stream 4 words (A0..A3), `ld_last` on A3, one `ld_valid` gap after A1 → `ld_count`=4, `core_rst`=0 the cycle after A3, `ir` at pc=2 equals A2.
- RUN: store 32'hDEAD_BEEF to addr 7, same-cycle read of addr 7 → old value; next cycle read → 32'hDEAD_BEEF.
- RUN: `d_wen` to addr 2^AW+3 → array[3] unchanged, `oob_err`=1, `d_rdata`=0; `pc`=2^AW → `ir`=`NOP_WORD`.
- Stream 2^AW words with no `ld_last` → auto RUN, `ld_count`=2^AW, `ld_ready`=0 afterwards.
- Assert `rst` after 2 of 4 load words → IDLE next evaluation, `core_rst`=1. A fresh `ld_start` restarts at address 0 and `oob_err` stays 0.
